clk_div_multi: RTL and testbench
================================

# clk_div_multi

Multi-channel, run-time programmable clock divider. It replaces the fixed single-output, compile-time divider. Each channel produces a 50 % duty divided clock `O_CLK[i]` and a one-cycle rising-edge strobe `O_TICK[i]` from the system clock. Each channel has its own enable and its own half-period value. Divide values are written through a shared write port and take effect only at a full-period boundary, so the output never glitches. The block sits at the top level and feeds slow clocks and enables to display, debounce and single-step logic.

## Interface
- `CHANNELS`, default 4: number of independent divider channels (1..16).
- `CNT_W`, default 32: width of the divide value and of each channel counter.
- `DEF_DIV`, default 2: half-period loaded into every channel (active and shadow) at reset.
- `SEL_W`, default 2: width of `div_sel`; must satisfy 2^SEL_W >= CHANNELS.
- `I_CLK`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  CHANNELS  per-channel run enable.
- `div_we`  in  1  write strobe for a divide value.
- `div_sel`  in  SEL_W  target channel of the write.
- `div_val`  in  CNT_W  new half-period N, in I_CLK cycles.
- `O_CLK`  out  CHANNELS  divided clocks, registered.
- `O_TICK`  out  CHANNELS  one-cycle pulse coincident with each 0->1 of `O_CLK[i]`, registered.
- `div_pend`  out  CHANNELS  a written value is waiting in the shadow register.

## Operation
- Per-channel state:
  - `act[i]`: active half-period.
  - `shd[i]`: shadow half-period.
  - `cnt[i]`: counter, CNT_W bits.
  - `O_CLK[i]`.
  - `div_pend[i]`.
- Reset:
  - `cnt`=0, `O_CLK`=0, `O_TICK`=0, `div_pend`=0.
  - `act`=`shd`=DEF_DIV.
  - `rst` overrides every other input, including in-progress periods and pending writes.
- Running, defined as `en[i]`=1 and `act[i]`!=0:
  - If `cnt[i]` == `act[i]`-1: toggle `O_CLK[i]` and set `cnt[i]`<=0.
  - Otherwise: `cnt[i]`<=`cnt[i]`+1.
  - Output period = 2·N I_CLK cycles, high N, low N.
  - N=1 gives I_CLK/2.
- `O_TICK[i]` is 1 in exactly the cycles where `O_CLK[i]` has just registered 0->1. It is 0 otherwise.
- Write:
  - When `div_we`=1 and `div_sel` < CHANNELS: `shd[div_sel]`<=`div_val` and `div_pend[div_sel]`<=1.
  - When `div_sel` >= CHANNELS: the write is ignored and no state changes.
- Boundary load:
  - A boundary is a cycle where the channel's counter is at `act`-1 and `O_CLK[i]`=1, i.e. the falling toggle that completes a full period.
  - At a boundary with `div_pend[i]`=1: `act[i]`<=`shd[i]` and `div_pend[i]`<=0. The toggle to 0 and `cnt`<=0 still occur.
- Disabled or stopped, i.e. `en[i]`=0 or `act[i]`=0:
  - `cnt[i]`<=0 and `O_CLK[i]`<=0 on the next edge; `O_TICK[i]`=0.
  - If `div_pend[i]`=1, load `shd` into `act` immediately and clear `div_pend`.
  - A stopped channel restarts with a full low half-period.
- Write colliding with a boundary on the same channel, in the same cycle:
  - The boundary loads the old `shd`.
  - The new value is written to `shd` and `div_pend` stays 1.
  - The new value is applied at the next boundary.
- A second write before the boundary overwrites the shadow; only the last value is applied.
- `div_val`=0 written to a running channel stops it at the next boundary. `O_CLK` then stays 0.
- Counter compare uses the full CNT_W bits. `act` up to 2^CNT_W-1 is legal, and `cnt` never wraps past `act`-1.
- Channels are fully independent. Writes target one channel per cycle.

## Timing
- Rising edges are numbered from the edge at which `rst` is first sampled low with `en[i]`=1; that edge is 1.
- For a channel running with half-period N:
  - `O_CLK[i]` rises after edge N, falls after edge 2N, rises again after edge 3N, and so on.
  - `O_TICK[i]`=1 during the cycle following edges N, 3N, 5N, and so on.
- Write latency:
  - `shd`/`div_pend` update one edge after the `div_we` cycle.
  - `act` updates at the first boundary strictly after that.
  - On a stopped channel, `act` updates one edge after `div_pend` is seen.
- `en` 1->0: `O_CLK` is 0 one edge later.
- `en` 0->1: the first rise comes N edges later.
- All outputs are registered, with no combinational path from any input to any output.

## Test plan
- Reset, DEF_DIV=2, all `en`=1:
  - Every `O_CLK` toggles every 2 cycles, with period 4.
  - `O_TICK` pulses 1 cycle per 4.
  - `div_pend`=0.
- Write `div_sel`=1, `div_val`=5 mid-high-phase:
  - `div_pend[1]`=1 until the next falling edge of `O_CLK[1]`, then clears.
  - The following period is exactly 10 high/low cycles (5/5).
  - Channels 0, 2 and 3 are undisturbed.
- Write landing on the boundary cycle of channel 2 (`div_val`=3, old N=2):
  - The next period is still 4.
  - The period after that is 6.
  - `div_pend[2]` stays 1 across the collision.
- `en[0]`=0 for 7 cycles, then 1, with N=4:
  - `O_CLK[0]`=0 one edge after deassert, no `O_TICK` while disabled.
  - The first rise comes exactly 4 edges after re-enable.
- Write `div_val`=0 to channel 3, then `div_val`=1:
  - The channel stops low after its current period.
  - It then runs at I_CLK/2, with `O_TICK[3]` every other cycle.
- Assert `rst` mid-period with a write pending, then check `div_sel`=7 (CHANNELS=4):
  - All outputs return to 0, `act`=2 and `div_pend`=0.
  - The `div_sel`=7 write changes nothing.

Source files
------------

// File: rtl/clk_div_multi.sv
// Multi-channel run-time programmable clock divider with 50% duty outputs,
// rising-edge strobes and glitch-free shadowed divide-value updates.
module clk_div_multi #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 32,
   parameter int DEF_DIV  = 2,
   parameter int SEL_W    = 2
) (
   input  logic                I_CLK,
   input  logic                rst,
   input  logic [CHANNELS-1:0] en,
   input  logic                div_we,
   input  logic [SEL_W-1:0]    div_sel,
   input  logic [CNT_W-1:0]    div_val,
   output logic [CHANNELS-1:0] O_CLK,
   output logic [CHANNELS-1:0] O_TICK,
   output logic [CHANNELS-1:0] div_pend
);

   localparam logic [CNT_W-1:0] DEF_VAL = CNT_W'(DEF_DIV);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

   logic [CNT_W-1:0]    r_act [CHANNELS];
   logic [CNT_W-1:0]    r_shd [CHANNELS];
   logic [CNT_W-1:0]    r_cnt [CHANNELS];
   logic [CHANNELS-1:0] r_clk;
   logic [CHANNELS-1:0] r_tick;
   logic [CHANNELS-1:0] r_pend;

   logic [CHANNELS-1:0] w_run;
   logic [CHANNELS-1:0] w_top;
   logic [CHANNELS-1:0] w_wr;

   // A channel with a zero active half-period is treated exactly like a disabled one.
   always_comb begin
      w_run = '0;
      w_top = '0;
      w_wr  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_run[i] = en[i] && (r_act[i] != '0);
         w_top[i] = (r_cnt[i] == (r_act[i] - ONE));
         w_wr[i]  = div_we && (div_sel == SEL_W'(i));
      end
   end

   always_ff @(posedge I_CLK) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_act[i] <= DEF_VAL;
            r_shd[i] <= DEF_VAL;
            r_cnt[i] <= '0;
         end
         r_clk  <= '0;
         r_tick <= '0;
         r_pend <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_run[i]) begin
               if (w_top[i]) begin
                  r_clk[i]  <= ~r_clk[i];
                  r_tick[i] <= ~r_clk[i];
                  r_cnt[i]  <= '0;
                  // The falling toggle closes a full period: safe point to swap in the shadow.
                  if (r_clk[i] && r_pend[i]) begin
                     r_act[i]  <= r_shd[i];
                     r_pend[i] <= 1'b0;
                  end
               end else begin
                  r_cnt[i]  <= r_cnt[i] + ONE;
                  r_tick[i] <= 1'b0;
               end
            end else begin
               r_cnt[i]  <= '0;
               r_clk[i]  <= 1'b0;
               r_tick[i] <= 1'b0;
               if (r_pend[i]) begin
                  r_act[i]  <= r_shd[i];
                  r_pend[i] <= 1'b0;
               end
            end
            // A same-cycle write wins over the load above, so the new value stays pending.
            if (w_wr[i]) begin
               r_shd[i]  <= div_val;
               r_pend[i] <= 1'b1;
            end
         end
      end
   end

   assign O_CLK    = r_clk;
   assign O_TICK   = r_tick;
   assign div_pend = r_pend;

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (4 channels, 3-bit select so
// an out-of-range channel number can be written).
module tb_clk_div_multi;

   logic        I_CLK;
   logic        rst;
   logic [3:0]  en;
   logic        div_we;
   logic [2:0]  div_sel;
   logic [31:0] div_val;
   logic [3:0]  O_CLK;
   logic [3:0]  O_TICK;
   logic [3:0]  div_pend;

   int checks = 0;
   int errors = 0;
   int edgeNo = 0;

   clk_div_multi #(
      .CHANNELS(4),
      .CNT_W(32),
      .DEF_DIV(2),
      .SEL_W(3)
   ) dut (
      .I_CLK(I_CLK),
      .rst(rst),
      .en(en),
      .div_we(div_we),
      .div_sel(div_sel),
      .div_val(div_val),
      .O_CLK(O_CLK),
      .O_TICK(O_TICK),
      .div_pend(div_pend)
   );

   initial I_CLK = 1'b0;
   always #5 I_CLK = ~I_CLK;

   task automatic step();
      @(posedge I_CLK);
      #1;
      edgeNo++;
   endtask

   task automatic applyStimulus(input logic we, input logic [2:0] sel, input logic [31:0] val);
      div_we  = we;
      div_sel = sel;
      div_val = val;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Steady-state waveform of a channel running N=2 since edge 1.
   function automatic logic clkN2(input int k);
      return ((k / 2) % 2) == 1;
   endfunction

   function automatic logic tickN2(input int k);
      return (k % 4) == 2;
   endfunction

   logic expClk;
   logic expTick;
   logic expPend;

   initial begin
      rst = 1'b1;
      en  = 4'hF;
      applyStimulus(1'b0, 3'd0, 32'd0);

      // Reset state
      step();
      step();
      checkOutput("reset outputs", {20'd0, O_CLK, O_TICK, div_pend}, 32'd0);

      // N=2 on every channel from the first enabled edge
      rst    = 1'b0;
      edgeNo = 0;
      while (edgeNo < 10) begin
         step();
         checkOutput($sformatf("def e%0d", edgeNo), {20'd0, O_CLK, O_TICK, div_pend},
                     {20'd0, {4{clkN2(edgeNo)}}, {4{tickN2(edgeNo)}}, 4'h0});
      end

      // Write 5 to channel 1 during its high phase
      checkOutput("ch1 high before write", {31'd0, O_CLK[1]}, 32'd1);
      applyStimulus(1'b1, 3'd1, 32'd5);
      while (edgeNo < 27) begin
         step();
         applyStimulus(1'b0, 3'd0, 32'd0);
         expClk  = (edgeNo == 11) || (edgeNo >= 17 && edgeNo <= 21) || (edgeNo == 27);
         expTick = (edgeNo == 17) || (edgeNo == 27);
         expPend = (edgeNo == 11);
         checkOutput($sformatf("ch1 e%0d", edgeNo), {29'd0, O_CLK[1], O_TICK[1], div_pend[1]},
                     {29'd0, expClk, expTick, expPend});
         checkOutput($sformatf("others e%0d", edgeNo),
                     {26'd0, O_CLK[3], O_CLK[2], O_CLK[0], O_TICK[3], O_TICK[2], O_TICK[0]},
                     {26'd0, {3{clkN2(edgeNo)}}, {3{tickN2(edgeNo)}}});
      end

      // Channel 2: pending value 2, then value 3 written on the boundary cycle
      while (edgeNo < 45) begin
         step();
         if (edgeNo == 28) applyStimulus(1'b1, 3'd2, 32'd2);
         else if (edgeNo == 31) applyStimulus(1'b1, 3'd2, 32'd3);
         else applyStimulus(1'b0, 3'd0, 32'd0);
         if (edgeNo <= 36) begin
            expClk  = clkN2(edgeNo);
            expTick = tickN2(edgeNo);
         end else begin
            expClk  = (edgeNo >= 39 && edgeNo <= 41) || (edgeNo == 45);
            expTick = (edgeNo == 39) || (edgeNo == 45);
         end
         expPend = (edgeNo >= 29) && (edgeNo <= 35);
         checkOutput($sformatf("ch2 e%0d", edgeNo), {29'd0, O_CLK[2], O_TICK[2], div_pend[2]},
                     {29'd0, expClk, expTick, expPend});
      end

      // Channel 0: disable for 7 edges while N=4 is written, then re-enable
      step();
      checkOutput("ch0 high before disable", {31'd0, O_CLK[0]}, 32'd1);
      en = 4'b1110;
      applyStimulus(1'b1, 3'd0, 32'd4);
      while (edgeNo < 61) begin
         step();
         applyStimulus(1'b0, 3'd0, 32'd0);
         if (edgeNo == 53) en = 4'hF;
         expClk  = (edgeNo >= 57) && (edgeNo <= 60);
         expTick = (edgeNo == 57);
         expPend = (edgeNo == 47);
         checkOutput($sformatf("ch0 e%0d", edgeNo), {29'd0, O_CLK[0], O_TICK[0], div_pend[0]},
                     {29'd0, expClk, expTick, expPend});
      end

      // Channel 3: stop with 0, then restart at N=1
      applyStimulus(1'b1, 3'd3, 32'd0);
      while (edgeNo < 74) begin
         step();
         if (edgeNo == 66) applyStimulus(1'b1, 3'd3, 32'd1);
         else applyStimulus(1'b0, 3'd0, 32'd0);
         expClk  = (edgeNo < 64) || ((edgeNo >= 69) && (edgeNo % 2 == 1));
         expTick = (edgeNo == 62) || ((edgeNo >= 69) && (edgeNo % 2 == 1));
         expPend = (edgeNo <= 63) || (edgeNo == 67);
         checkOutput($sformatf("ch3 e%0d", edgeNo), {29'd0, O_CLK[3], O_TICK[3], div_pend[3]},
                     {29'd0, expClk, expTick, expPend});
      end

      // Reset with a write pending and another write presented during reset
      applyStimulus(1'b1, 3'd1, 32'd9);
      step();
      checkOutput("pend before reset", {28'd0, div_pend}, 32'h2);
      rst = 1'b1;
      applyStimulus(1'b1, 3'd0, 32'd9);
      step();
      checkOutput("reset mid-period", {20'd0, O_CLK, O_TICK, div_pend}, 32'd0);

      // Out-of-range channel write on the first edge after reset
      rst    = 1'b0;
      applyStimulus(1'b1, 3'd7, 32'd9);
      edgeNo = 0;
      while (edgeNo < 9) begin
         step();
         applyStimulus(1'b0, 3'd0, 32'd0);
         checkOutput($sformatf("post-reset e%0d", edgeNo), {20'd0, O_CLK, O_TICK, div_pend},
                     {20'd0, {4{clkN2(edgeNo)}}, {4{tickN2(edgeNo)}}, 4'h0});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
